// File: rtl/alu_result_checker.sv
// Self-checking harness for an external ALU: issues registered test vectors, waits SETTLE cycles,
// then compares the ALU result/zero flag. Optional build macro: ALU_CHECK_STOP_ON_FAIL_EN.
module alu_result_checker #(
   parameter int WIDTH  = 32,
   parameter int SETTLE = 1,
   parameter int CW     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             vec_valid,
   output logic             vec_ready,
   input  logic             vec_last,
   input  logic [WIDTH-1:0] vec_a,
   input  logic [WIDTH-1:0] vec_b,
   input  logic [2:0]       vec_f,
   input  logic [WIDTH-1:0] vec_y,
   input  logic             vec_z,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_f,
   input  logic [WIDTH-1:0] alu_y,
   input  logic             alu_z,
   output logic             mismatch,
   output logic [CW-1:0]    pass_cnt,
   output logic [CW-1:0]    fail_cnt,
   output logic             first_fail_vld,
   output logic [CW-1:0]    first_fail_idx,
   output logic             done,
   output logic [1:0]       state_dbg
);

   // vec_valid/vec_ready: a vector transfers on a rising edge where both are 1;
   // vec_ready is high only while idle, and the vector fields are sampled only on that edge.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [3:0]    SETTLE_INIT = 4'(SETTLE - 1);
   localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};

   state_t           state_q, state_d;
   logic [3:0]       settle_q, settle_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [2:0]       alu_f_q, alu_f_d;
   logic [WIDTH-1:0] exp_y_q, exp_y_d;
   logic             exp_z_q, exp_z_d;
   logic             last_q, last_d;
   logic             mismatch_q, mismatch_d;
   logic [CW-1:0]    pass_q, pass_d;
   logic [CW-1:0]    fail_q, fail_d;
   logic             ffv_q, ffv_d;
   logic [CW-1:0]    ffi_q, ffi_d;
   logic [CW-1:0]    idx_q, idx_d;
   logic             match;

   always_comb begin
      state_d    = state_q;
      settle_d   = settle_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_f_d    = alu_f_q;
      exp_y_d    = exp_y_q;
      exp_z_d    = exp_z_q;
      last_d     = last_q;
      mismatch_d = 1'b0;
      pass_d     = pass_q;
      fail_d     = fail_q;
      ffv_d      = ffv_q;
      ffi_d      = ffi_q;
      idx_d      = idx_q;
      match      = (alu_y == exp_y_q) && (alu_z == exp_z_q);

      case (state_q)
         ST_IDLE: begin
            if (vec_valid) begin
               alu_a_d  = vec_a;
               alu_b_d  = vec_b;
               alu_f_d  = vec_f;
               exp_y_d  = vec_y;
               exp_z_d  = vec_z;
               last_d   = vec_last;
               settle_d = SETTLE_INIT;
               state_d  = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (settle_q == 4'd0) state_d = ST_CHECK;
            else                  settle_d = settle_q - 4'd1;
         end
         ST_CHECK: begin
            if (match) begin
               if (pass_q != CNT_MAX) pass_d = pass_q + 1'b1;
            end else begin
               if (fail_q != CNT_MAX) fail_d = fail_q + 1'b1;
               mismatch_d = 1'b1;
               if (!ffv_q) begin
                  ffv_d = 1'b1;
                  ffi_d = idx_q;
               end
            end
            if (idx_q != CNT_MAX) idx_d = idx_q + 1'b1;
            state_d = last_q ? ST_DONE : ST_IDLE;
`ifdef ALU_CHECK_STOP_ON_FAIL_EN
            if (!match) state_d = ST_DONE;
`endif
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         settle_q   <= 4'd0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_f_q    <= '0;
         exp_y_q    <= '0;
         exp_z_q    <= 1'b0;
         last_q     <= 1'b0;
         mismatch_q <= 1'b0;
         pass_q     <= '0;
         fail_q     <= '0;
         ffv_q      <= 1'b0;
         ffi_q      <= '0;
         idx_q      <= '0;
      end else begin
         state_q    <= state_d;
         settle_q   <= settle_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_f_q    <= alu_f_d;
         exp_y_q    <= exp_y_d;
         exp_z_q    <= exp_z_d;
         last_q     <= last_d;
         mismatch_q <= mismatch_d;
         pass_q     <= pass_d;
         fail_q     <= fail_d;
         ffv_q      <= ffv_d;
         ffi_q      <= ffi_d;
         idx_q      <= idx_d;
      end
   end

   assign vec_ready      = (state_q == ST_IDLE);
   assign done           = (state_q == ST_DONE);
   assign alu_a          = alu_a_q;
   assign alu_b          = alu_b_q;
   assign alu_f          = alu_f_q;
   assign mismatch       = mismatch_q;
   assign pass_cnt       = pass_q;
   assign fail_cnt       = fail_q;
   assign first_fail_vld = ffv_q;
   assign first_fail_idx = ffi_q;
   assign state_dbg      = state_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed + randomized bench for alu_result_checker with a behavioural ALU and outcome model.
module tb_alu_result_checker;

   localparam int W    = 32;
   localparam int S    = 3;
   localparam int C    = 4;
   localparam int MAXC = (1 << C) - 1;
`ifdef ALU_CHECK_STOP_ON_FAIL_EN
   localparam bit STOP = 1'b1;
`else
   localparam bit STOP = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         vec_valid = 1'b0;
   logic         vec_ready;
   logic         vec_last = 1'b0;
   logic [W-1:0] vec_a = '0, vec_b = '0, vec_y = '0;
   logic [2:0]   vec_f = '0;
   logic         vec_z = 1'b0;
   logic [W-1:0] alu_a, alu_b, alu_y;
   logic [2:0]   alu_f;
   logic         alu_z;
   logic         mismatch, first_fail_vld, done;
   logic [C-1:0] pass_cnt, fail_cnt, first_fail_idx;
   logic [1:0]   state_dbg;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int prev_acc = 0;
   int mism_seen = 0;
   int exp_pass, exp_fail, exp_idx, exp_ffi, exp_mism;
   bit exp_ffv, exp_done;

   alu_result_checker #(.WIDTH(W), .SETTLE(S), .CW(C)) dut (
      .clk(clk), .reset(reset),
      .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_last(vec_last),
      .vec_a(vec_a), .vec_b(vec_b), .vec_f(vec_f), .vec_y(vec_y), .vec_z(vec_z),
      .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_y(alu_y), .alu_z(alu_z),
      .mismatch(mismatch), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
      .first_fail_vld(first_fail_vld), .first_fail_idx(first_fail_idx),
      .done(done), .state_dbg(state_dbg)
   );

   // clock / cycle counter / mismatch pulse monitor
   always #5 clk = ~clk;
   always @(negedge clk) begin
      cyc++;
      if (mismatch === 1'b1) mism_seen++;
   end

   function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] f);
      case (f)
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b010:  return a + b;
         3'b100:  return a & ~b;
         3'b101:  return a | ~b;
         3'b110:  return a - b;
         3'b111:  return ($signed(a) < $signed(b)) ? 1 : 0;
         default: return '0;
      endcase
   endfunction

   // ALU under test: a correct behavioural ALU
   assign alu_y = ref_alu(alu_a, alu_b, alu_f);
   assign alu_z = (alu_y == '0);

   function automatic int sat_inc(input int v);
      return (v == MAXC) ? v : v + 1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_pass"}, 32'(pass_cnt), exp_pass);
      check({tag, "_fail"}, 32'(fail_cnt), exp_fail);
      check({tag, "_ffv"}, 32'(first_fail_vld), 32'(exp_ffv));
      check({tag, "_ffi"}, 32'(first_fail_idx), exp_ffi);
      check({tag, "_done"}, 32'(done), 32'(exp_done));
   endtask

   task automatic model_clear();
      exp_pass = 0; exp_fail = 0; exp_idx = 0; exp_ffi = 0;
      exp_ffv = 1'b0; exp_done = 1'b0;
   endtask

   // driver: entered and left on a falling edge
   task automatic do_reset();
      reset = 1'b1;
      vec_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      model_clear();
      check("rst_ready", 32'(vec_ready), 1);
      check("rst_state", 32'(state_dbg), 0);
      check("rst_mismatch", 32'(mismatch), 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_f", 32'(alu_f), 0);
      check_counts("rst");
   endtask

   task automatic send_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f,
                           input logic [W-1:0] y, input logic z, input logic last,
                           input bit b2b);
      logic [W-1:0] r;
      bit ok;
      int n;
      r  = ref_alu(a, b, f);
      ok = (y == r) && (z == (r == '0));
      vec_a = a; vec_b = b; vec_f = f; vec_y = y; vec_z = z; vec_last = last;
      vec_valid = 1'b1;
      if (exp_done) begin
         repeat (10) begin
            @(negedge clk);
            check("ignored_ready", 32'(vec_ready), 0);
         end
         vec_valid = 1'b0;
         check_counts("ignored");
         return;
      end
      n = 0;
      while (vec_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("accept_ready", 32'(vec_ready), 1);
      @(posedge clk);
      if (b2b) check("throughput", cyc - prev_acc, S + 2);
      prev_acc = cyc;
      @(negedge clk);
      vec_valid = 1'b0;
      vec_a = $urandom; vec_b = $urandom; vec_f = 3'($urandom);
      vec_y = $urandom; vec_z = 1'($urandom); vec_last = 1'($urandom);
      if (ok) exp_pass = sat_inc(exp_pass);
      else begin
         exp_fail = sat_inc(exp_fail);
         exp_mism++;
         if (!exp_ffv) begin
            exp_ffv = 1'b1;
            exp_ffi = exp_idx;
         end
      end
      exp_idx = sat_inc(exp_idx);
      if (last || (STOP && !ok)) exp_done = 1'b1;
      n = 0;
      while (!(vec_ready === 1'b1 || done === 1'b1) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("complete", 32'(vec_ready | done), 1);
      check("mismatch_pulse", 32'(mismatch), 32'(!ok));
      check("alu_a_hold", alu_a, a);
      check("alu_b_hold", alu_b, b);
      check("alu_f_hold", 32'(alu_f), 32'(f));
      check_counts("vec");
   endtask

   task automatic send_rand(input bit force_ok, input logic last, input bit b2b);
      logic [W-1:0] a, b, y;
      logic [2:0] f;
      logic z;
      a = $urandom_range(0, 3) == 0 ? W'($urandom_range(0, 3)) : W'($urandom);
      b = $urandom_range(0, 3) == 0 ? a : W'($urandom);
      f = 3'($urandom_range(0, 7));
      y = ref_alu(a, b, f);
      z = (y == '0);
      if (!force_ok && $urandom_range(0, 3) == 0) begin
         if ($urandom_range(0, 1) == 0) y = y ^ (W'(1) << $urandom_range(0, W - 1));
         else                           z = ~z;
      end
      send_vec(a, b, f, y, z, last, b2b);
   endtask

   initial begin
      exp_mism = 0;
      model_clear();
      repeat (2) @(negedge clk);
      do_reset();

      // add, subtract-to-zero, injected failure at index 2, then later failure
      send_vec(32'd5, 32'd3, 3'b010, 32'd8, 1'b0, 1'b0, 1'b0);
      send_vec(32'd3, 32'd3, 3'b110, 32'd0, 1'b1, 1'b0, 1'b1);
      send_vec(32'd5, 32'd3, 3'b010, 32'h0000_0009, 1'b0, 1'b0, 1'b1);
      send_rand(1'b1, 1'b0, 1'b1);
      send_vec(32'd7, 32'd1, 3'b110, 32'd6, 1'b1, 1'b0, 1'b1);
      check("ffi_kept", 32'(first_fail_idx), exp_ffi);
      send_rand(1'b0, 1'b0, 1'b1);
      send_rand(1'b0, 1'b0, 1'b1);
      send_rand(1'b1, 1'b1, 1'b1);
      check("done_after_last", 32'(done), 1);
      check("ready_after_last", 32'(vec_ready), 0);
      send_rand(1'b1, 1'b0, 1'b0);

      // reset while the second vector is settling
      do_reset();
      send_vec(32'd1, 32'd2, 3'b010, 32'd3, 1'b0, 1'b0, 1'b0);
      vec_a = 32'd9; vec_b = 32'd9; vec_f = 3'b110; vec_y = 32'd0; vec_z = 1'b1;
      vec_last = 1'b0; vec_valid = 1'b1;
      @(negedge clk);
      vec_valid = 1'b0;
      check("mid_settle_state", 32'(state_dbg), 1);
      do_reset();
      repeat (S + 3) @(negedge clk);
      check_counts("after_abort");

      // failure on vector 0 of 4
      do_reset();
      send_vec(32'd4, 32'd4, 3'b000, 32'd5, 1'b0, 1'b0, 1'b0);
      send_rand(1'b1, 1'b0, 1'b1);
      send_rand(1'b1, 1'b0, 1'b1);
      send_rand(1'b1, 1'b1, 1'b1);
      check("stop_fail_cnt", 32'(fail_cnt), 1);
      check("stop_pass_cnt", 32'(pass_cnt), STOP ? 0 : 3);
      check("stop_done", 32'(done), 1);

      // saturation run
      do_reset();
      for (int i = 0; i < 24; i++) send_rand(i < 17, i == 23, i != 0);

      repeat (3) @(negedge clk);
      check("mismatch_pulses", mism_seen, exp_mism);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
